// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: divide FSM states,
// divide timing and forwarding mux select encodings.
package hazard_pkg;

  localparam int unsigned DIV_CYCLES = 32;
  localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Memory wins over Writeback because it holds the younger result.
  // Register 0 is hardwired to zero and is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [4:0] src,
    input logic [4:0] wreg_m,
    input logic       wen_m,
    input logic [4:0] wreg_w,
    input logic       wen_w
  );
    if (src != 5'd0 && src == wreg_m && wen_m)      return FWD_MEM;
    else if (src != 5'd0 && src == wreg_w && wen_w) return FWD_WB;
    else                                            return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_div_stall_fsm.sv
// Multi-cycle divider sequencer: holds the front of the pipeline for the
// divide's duration and pulses done for one cycle when the result is ready.
module div_stall_fsm
  import hazard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic div_start,
  output logic div_stall,
  output logic busy,
  output logic done
);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: defaults first so no path through the case leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      DIV_IDLE: begin
        if (div_start) begin
          state_next = DIV_BUSY;
          cnt_next   = '0;
        end
      end
      DIV_BUSY: begin
        cnt_next = cnt + CNT_W'(1);
        if (cnt == DIV_LAST) state_next = DIV_DONE;
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // The start cycle itself stalls, so a divide costs DIV_CYCLES + 1 stalls.
  assign div_stall = ((state == DIV_IDLE) && div_start) || (state == DIV_BUSY);
  assign busy      = (state == DIV_BUSY);
  assign done      = (state == DIV_DONE);

endmodule

// File: rtl/hazard.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use and branch
// interlocks, and the stall/flush control around a multi-cycle divider.
module hazard
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic       branchD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic       regwriteE,
  input  logic       memtoregE,
  input  logic [4:0] writeregM,
  input  logic       regwriteM,
  input  logic       memtoregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteW,
  input  logic       divstartE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       divbusy,
  output logic       divdoneE
);

  logic lwstall;
  logic branchstall;
  logic divstall;

  assign forwardAE = fwd_select(rsE, writeregM, regwriteM, writeregW, regwriteW);
  assign forwardBE = fwd_select(rtE, writeregM, regwriteM, writeregW, regwriteW);

  // Decode comparator only taps the Memory stage; Writeback goes through
  // the register file's write-before-read.
  assign forwardAD = (rsD != 5'd0) && (rsD == writeregM) && regwriteM;
  assign forwardBD = (rtD != 5'd0) && (rtD == writeregM) && regwriteM;

  assign lwstall = memtoregE && ((rsD == rtE) || (rtD == rtE));

  assign branchstall = branchD &&
                       ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                        (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

  div_stall_fsm u_div (
    .clk       (clk),
    .rst       (rst),
    .div_start (divstartE),
    .div_stall (divstall),
    .busy      (divbusy),
    .done      (divdoneE)
  );

  assign stallF = lwstall || branchstall || divstall;
  assign stallD = stallF;
  assign stallE = divstall;
  // A running divide owns Execute: the bubble is deferred until it drains.
  assign flushE = (lwstall || branchstall) && !divstall;

endmodule

// File: doc/hazard.md
HAZARD -- requirements
Module: hazard

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and SHALL name these ports clk and rst.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous active-high reset
- rsD, rtD  in  5  source registers in Decode
- branchD  in  1  branch in Decode
- rsE, rtE  in  5  source registers in Execute
- writeregE  in  5  destination register in Execute
- regwriteE, memtoregE  in  1  Execute write-back / load flags
- writeregM  in  5  destination register in Memory
- regwriteM, memtoregM  in  1  Memory write-back / load flags
- writeregW  in  5  destination register in Writeback
- regwriteW  in  1  Writeback write-back flag
- divstartE  in  1  divide instruction present in Execute
- stallF, stallD  out  1  hold PC and the IF/ID register
- stallE  out  1  hold the ID/EX register
- flushE  out  1  clear the ID/EX register (drives the controller's flushE)
- forwardAD, forwardBD  out  1  Decode comparator operand from Memory
- forwardAE, forwardBE  out  2  ALU operand select
- divbusy  out  1  divider occupying Execute
- divdoneE  out  1  one-cycle divide-complete pulse

Function
REQ-003 forwardAE SHALL be 10 when rsE≠0, rsE==writeregM and regwriteM are all true.
REQ-004 Otherwise, forwardAE SHALL be 01 when rsE≠0, rsE==writeregW and regwriteW are all true.
REQ-005 In all remaining cases forwardAE SHALL be 00.
REQ-006 forwardBE SHALL follow the same rules as forwardAE with rtE in place of rsE.
REQ-007 Memory-stage forwarding SHALL have priority over Writeback-stage forwarding.
REQ-008 forwardAD SHALL be 1 exactly when rsD≠0, rsD==writeregM and regwriteM are all true; forwardBD SHALL be the same with rtD.
REQ-009 lwstall SHALL be memtoregE & (rsD==rtE | rtD==rtE).
REQ-010 branchstall SHALL be branchD & ((regwriteE & (writeregE==rsD | writeregE==rtD)) | (memtoregM & (writeregM==rsD | writeregM==rtD))).
REQ-011 The divide FSM SHALL have states IDLE, BUSY and DONE, plus a 5-bit cycle counter.
REQ-012 IDLE SHALL go to BUSY when divstartE=1, loading the counter with 0; otherwise it SHALL stay in IDLE.
REQ-013 BUSY SHALL increment the counter each cycle and SHALL go to DONE when the counter reaches 31.
REQ-014 DONE SHALL go to IDLE unconditionally.
REQ-015 divstartE SHALL be ignored in BUSY and in DONE.
REQ-016 divstall SHALL be (IDLE & divstartE) | BUSY, giving 33 stall cycles per divide.
REQ-017 divbusy SHALL equal (state==BUSY); divdoneE SHALL equal (state==DONE).
REQ-018 stallF and stallD SHALL each be lwstall | branchstall | divstall.
REQ-019 stallE SHALL be divstall.
REQ-020 flushE SHALL be (lwstall | branchstall) & ~divstall, so the Execute instruction is held, never flushed, while a divide runs.
REQ-021 A lwstall and a branchstall in the same cycle SHALL produce one stall cycle with flushE=1, not two.
REQ-022 A divide in DONE followed immediately by another divstartE in the next cycle (IDLE) SHALL start a new divide.
REQ-023 All forwarding and stall outputs SHALL be combinational from inputs and state, with zero latency.

Reset
REQ-024 rst=1 SHALL force state to IDLE and the counter to 0 asynchronously, making divbusy=0 and divdoneE=0.
REQ-025 With all inputs at 0 during reset, every output SHALL be 0.
REQ-026 A reset asserted mid-divide SHALL abort the divide with no divdoneE pulse.

Structure
REQ-027 A shared package SHALL hold the FSM state encodings, DIV_CYCLES=32, and the forward-select encodings (00 register file, 01 Writeback, 10 Memory).
REQ-028 The divide FSM and counter SHALL be one sub-module, div_stall_fsm; all forwarding and stall logic SHALL stay in hazard.

Verification
REQ-029 Forwarding: rsE=rtE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardAE=forwardBE=10; drop regwriteM -> 01; set rsE=rtE=0 -> 00.
REQ-030 Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 and stallE=0 for exactly one cycle.
REQ-031 Branch: branchD=1, rsD=3, regwriteE=1, writeregE=3 -> stall plus flush; next cycle memtoregM=1, writeregM=3 -> stall again; then forwardAD=0 when regwriteM=0.
REQ-032 Divide: divstartE held high -> stallF/D/E=1 for 33 cycles, divbusy=1 for 32 cycles, then divdoneE=1 for one cycle with stalls=0.
REQ-033 Divide plus load-use: divstartE together with a lwstall condition -> flushE=0 throughout BUSY; flushE=1 at the first non-divide-stall cycle if the condition persists.
REQ-034 Reset: rst pulsed at counter=10 -> divbusy=0 immediately and no divdoneE pulse; a new divstartE afterwards takes the full 33 cycles.
